// File: rtl/hram_wb_arbiter.sv
// Two-master Wishbone B4 classic arbiter in front of the HyperRAM controller slave port.
// Round-robin grant held for the whole CYC, with a watchdog that aborts a hung slave cycle with ERR.
module hram_wb_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i
);

    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

    state_t        state, state_nxt;
    logic          last_grant, last_grant_nxt;
    logic [WW-1:0] wdog, wdog_nxt;
    logic          timeout;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wdog       <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            wdog       <= wdog_nxt;
        end
    end

    // Watchdog counts consecutive strobe cycles that the slave leaves unanswered.
    assign timeout = s_stb_o && !s_ack_i && !s_err_i && (wdog == WW'(TIMEOUT - 1));

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        if (state == IDLE || !s_stb_o || s_ack_i || s_err_i) begin
            wdog_nxt = '0;
        end else begin
            wdog_nxt = wdog + WW'(1);
        end
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_nxt = last_grant ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_nxt = GNT0;
                end else if (m1_cyc_i) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i || timeout) begin
                    state_nxt      = m0_cyc_i ? ABORT : IDLE;
                    last_grant_nxt = 1'b0;
                end
            end
            GNT1: begin
                if (!m1_cyc_i || timeout) begin
                    state_nxt      = m1_cyc_i ? ABORT : IDLE;
                    last_grant_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // In ABORT, last_grant already names the master whose cycle was killed.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i;
            end
            ABORT: begin
                m0_err_o = !last_grant;
                m1_err_o = last_grant;
            end
            default: ;
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_hram_wb_arbiter.sv
// Bench for hram_wb_arbiter: directed scenarios then random traffic, all checked each cycle
// against a transaction-level model of who owns the slave port and how long it has stalled.
module tb_hram_wb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          wb_clk = 1'b0;
    logic          wb_rst = 1'b1;
    logic          mcyc[2];
    logic          mstb[2];
    logic          mwe[2];
    logic [AW-1:0] madr[2];
    logic [DW-1:0] mdat[2];
    logic [SW-1:0] msel[2];
    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [SW-1:0] s_sel_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i, s_err_i;

    int vectors = 0;
    int miscompares = 0;

    // Model: owner of the slave port (-1 none), pending abort, last released owner, stalled beats.
    int own, abort_who, last, stall;
    bit abort_pend;
    int m_left[2];

    hram_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]), .m0_we_i(mwe[0]), .m0_adr_i(madr[0]),
        .m0_dat_i(mdat[0]), .m0_sel_i(msel[0]), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]), .m1_we_i(mwe[1]), .m1_adr_i(madr[1]),
        .m1_dat_i(mdat[1]), .m1_sel_i(msel[1]), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .s_err_i(s_err_i)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        own        = -1;
        abort_pend = 1'b0;
        abort_who  = 0;
        last       = 1;
        stall      = 0;
    endtask

    task automatic model_check();
        logic          e_cyc, e_stb, e_we;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        logic          e_ack[2];
        logic          e_err[2];
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
        e_adr = '0; e_dat = '0; e_sel = '0;
        e_ack[0] = 1'b0; e_ack[1] = 1'b0;
        e_err[0] = 1'b0; e_err[1] = 1'b0;
        if (own >= 0) begin
            e_cyc      = mcyc[own];
            e_stb      = mstb[own];
            e_we       = mwe[own];
            e_adr      = madr[own];
            e_dat      = mdat[own];
            e_sel      = msel[own];
            e_ack[own] = s_ack_i;
            e_err[own] = s_err_i;
        end
        if (abort_pend) e_err[abort_who] = 1'b1;
        checkOutput("s_cyc", s_cyc_o, e_cyc);
        checkOutput("s_stb", s_stb_o, e_stb);
        checkOutput("s_we", s_we_o, e_we);
        checkOutput("s_adr", s_adr_o, e_adr);
        checkOutput("s_dat", s_dat_o, e_dat);
        checkOutput("s_sel", s_sel_o, e_sel);
        checkOutput("m0_ack", m0_ack_o, e_ack[0]);
        checkOutput("m1_ack", m1_ack_o, e_ack[1]);
        checkOutput("m0_err", m0_err_o, e_err[0]);
        checkOutput("m1_err", m1_err_o, e_err[1]);
        checkOutput("m0_dat", m0_dat_o, s_dat_i);
        checkOutput("m1_dat", m1_dat_o, s_dat_i);
    endtask

    task automatic model_advance();
        if (abort_pend) begin
            abort_pend = 1'b0;
            stall      = 0;
        end else if (own < 0) begin
            stall = 0;
            if (mcyc[0] && mcyc[1]) own = 1 - last;
            else if (mcyc[0])       own = 0;
            else if (mcyc[1])       own = 1;
        end else if (!mcyc[own]) begin
            last  = own;
            own   = -1;
            stall = 0;
        end else if (mstb[own] && !s_ack_i && !s_err_i) begin
            if (stall == TO - 1) begin
                abort_pend = 1'b1;
                abort_who  = own;
                last       = own;
                own        = -1;
                stall      = 0;
            end else begin
                stall++;
            end
        end else begin
            stall = 0;
        end
    endtask

    task automatic sample();
        @(negedge wb_clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge wb_clk);
        model_advance();
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    task automatic clear_inputs();
        for (int m = 0; m < 2; m++) begin
            mcyc[m] = 1'b0; mstb[m] = 1'b0; mwe[m] = 1'b0;
            madr[m] = '0; mdat[m] = '0; msel[m] = '0;
            m_left[m] = 0;
        end
        s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
    endtask

    // Called just after a rising edge: the reset pulse lives entirely between clock edges.
    task automatic reset_pulse();
        wb_rst = 1'b1;
        #1;
        model_reset();
        model_check();
        checkOutput("rst_s_cyc", s_cyc_o, 1'b0);
        checkOutput("rst_s_stb", s_stb_o, 1'b0);
        checkOutput("rst_m1_ack", m1_ack_o, 1'b0);
        #1;
        wb_rst = 1'b0;
        advance();
    endtask

    task automatic applyStimulus(input int max_len, input int stb_pct, input int ack_pct,
                                 input int err_pct);
        for (int m = 0; m < 2; m++) begin
            if (!mcyc[m]) begin
                if ($urandom_range(2) == 0) begin
                    mcyc[m]   = 1'b1;
                    m_left[m] = 1 + int'($urandom_range(max_len - 1));
                end
            end else begin
                m_left[m]--;
                if (m_left[m] <= 0) mcyc[m] = 1'b0;
            end
            mstb[m] = mcyc[m] && (int'($urandom_range(99)) < stb_pct);
            mwe[m]  = 1'($urandom);
            madr[m] = $urandom;
            mdat[m] = $urandom;
            msel[m] = SW'($urandom);
        end
        s_ack_i = int'($urandom_range(99)) < ack_pct;
        s_err_i = !s_ack_i && (int'($urandom_range(99)) < err_pct);
        s_dat_i = $urandom;
    endtask

    initial begin
        int beat, stb_at, err_at, err_cnt, got;
        clear_inputs();
        model_reset();
        advance();
        reset_pulse();

        $display("[TB] scenario 1: lone m0 read");
        mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 32'h100; msel[0] = 4'hF;
        sample(); advance();
        sample(); checkOutput("t1_s_cyc_t1", s_cyc_o, 1'b1); advance();
        sample(); advance();
        s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
        sample();
        checkOutput("t1_m0_ack_t3", m0_ack_o, 1'b1);
        checkOutput("t1_m0_dat_t3", m0_dat_o, 32'hDEADBEEF);
        advance();
        clear_inputs();
        idle_cycles(2);

        $display("[TB] scenario 2: tie after reset then alternation");
        reset_pulse();
        mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 32'h110;
        mcyc[1] = 1'b1; mstb[1] = 1'b1; madr[1] = 32'h310;
        sample(); advance();
        mcyc[0] = 1'b0; mstb[0] = 1'b0; s_ack_i = 1'b1;
        sample();
        checkOutput("t2_m0_first_ack", m0_ack_o, 1'b1);
        checkOutput("t2_m0_first_adr", s_adr_o, 32'h110);
        advance();
        s_ack_i = 1'b0;
        sample(); checkOutput("t2_dead_idle", s_cyc_o, 1'b0); advance();
        mcyc[1] = 1'b0; mstb[1] = 1'b0; s_ack_i = 1'b1;
        sample();
        checkOutput("t2_m1_ack", m1_ack_o, 1'b1);
        checkOutput("t2_m1_adr", s_adr_o, 32'h310);
        advance();
        s_ack_i = 1'b0;
        mcyc[0] = 1'b1; mstb[0] = 1'b1; mcyc[1] = 1'b1; mstb[1] = 1'b1;
        sample(); advance();
        sample(); checkOutput("t2_tie_again_m0", s_adr_o, 32'h110); advance();
        clear_inputs();
        idle_cycles(3);

        $display("[TB] scenario 3: m1 burst with m0 waiting");
        mcyc[1] = 1'b1; mstb[1] = 1'b1; mwe[1] = 1'b1; madr[1] = 32'h200;
        mdat[1] = 32'hA0; msel[1] = 4'hF;
        beat = 0;
        for (int i = 0; i < 40 && beat < 4; i++) begin
            s_ack_i = (own == 1);
            if (beat >= 1) begin
                mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 32'h400;
            end
            sample();
            if (s_ack_i) begin
                checkOutput("t3_beat_adr", s_adr_o, 32'h200 + 32'(4 * beat));
                checkOutput("t3_beat_dat", s_dat_o, 32'hA0 + 32'(beat));
                checkOutput("t3_m0_blocked", m0_ack_o, 1'b0);
            end
            advance();
            if (s_ack_i) begin
                beat++;
                madr[1] = 32'h200 + 32'(4 * beat);
                mdat[1] = 32'hA0 + 32'(beat);
            end
        end
        checkOutput("t3_beats", 64'(beat), 64'd4);
        mcyc[1] = 1'b0; mstb[1] = 1'b0; s_ack_i = 1'b0;
        idle_cycles(2);
        s_ack_i = 1'b1; mcyc[0] = 1'b0; mstb[0] = 1'b0;
        sample();
        checkOutput("t3_m0_after_m1", m0_ack_o, 1'b1);
        checkOutput("t3_m0_adr", s_adr_o, 32'h400);
        advance();
        clear_inputs();
        idle_cycles(2);

        $display("[TB] scenario 4: watchdog abort of m1");
        mcyc[1] = 1'b1; mstb[1] = 1'b1; madr[1] = 32'h600;
        stb_at = -1; err_at = -1; err_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            sample();
            if (s_stb_o === 1'b1 && stb_at < 0) stb_at = i;
            if (m1_err_o === 1'b1) begin
                err_cnt++;
                err_at = i;
                checkOutput("t4_abort_s_cyc", s_cyc_o, 1'b0);
            end
            advance();
            if (err_cnt > 0) begin
                mcyc[1] = 1'b0; mstb[1] = 1'b0;
            end
        end
        checkOutput("t4_err_delay", 64'(err_at - stb_at), 64'd16);
        checkOutput("t4_err_count", 64'(err_cnt), 64'd1);
        mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 32'h700; s_dat_i = 32'h12345678;
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            s_ack_i = (own == 0);
            sample();
            advance();
            if (s_ack_i) got = 1;
        end
        checkOutput("t4_m0_read_done", 64'(got), 64'd1);
        clear_inputs();
        idle_cycles(3);

        $display("[TB] scenario 5: slave error on m0 write");
        mcyc[0] = 1'b1; mstb[0] = 1'b1; mwe[0] = 1'b1; madr[0] = 32'h800; mdat[0] = 32'h55;
        for (int i = 0; i < 4 && own != 0; i++) begin
            sample();
            advance();
        end
        s_err_i = 1'b1;
        sample();
        checkOutput("t5_m0_err", m0_err_o, 1'b1);
        checkOutput("t5_m0_ack", m0_ack_o, 1'b0);
        advance();
        s_err_i = 1'b0;
        sample(); checkOutput("t5_grant_held", s_cyc_o, 1'b1); advance();
        mcyc[0] = 1'b0; mstb[0] = 1'b0;
        idle_cycles(3);

        $display("[TB] scenario 6: reset mid m1 read");
        mcyc[1] = 1'b1; mstb[1] = 1'b1; madr[1] = 32'h900;
        idle_cycles(2);
        mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 32'hA00;
        reset_pulse();
        sample(); checkOutput("t6_first_grant_m0", s_adr_o, 32'hA00); advance();
        clear_inputs();
        idle_cycles(3);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(12, 75, 30, 5);
            sample();
            advance();
        end
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(40, 100, 3, 0);
            sample();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
